// File: rtl/bist_pkg.sv
// Shared types and default sizing for the BIST sequencer.
package bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StRun,
    StDone
  } bist_state_e;

  localparam int unsigned DefRoundLen = 4;
  localparam int unsigned DefNRounds  = 2;

endpackage

// File: rtl/bist_cycle_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count flag; wraps to 0 after Last.
module bist_cycle_counter #(
  parameter int unsigned Width = 3,
  parameter int unsigned Last  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [Width-1:0] count,
  output logic             last
);

  localparam logic [Width-1:0] LastVal = Width'(Last);

  logic [Width-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LastVal) ? '0 : count_q + Width'(1);
    end
  end

  assign count = count_q;
  assign last  = (count_q == LastVal);

endmodule

// File: rtl/bist_controller.sv
// BIST run sequencer: one init cycle, ROUND_LEN*N_ROUNDS running cycles with inter-round
// toggles, a finish pulse, then a sticky bist_end flag.
module bist_controller
  import bist_pkg::*;
#(
  parameter int unsigned ROUND_LEN = DefRoundLen,
  parameter int unsigned N_ROUNDS  = DefNRounds
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic init,
  output logic running,
  output logic toggle,
  output logic finish,
  output logic bist_end
);

  localparam int unsigned TotalCycles = ROUND_LEN * N_ROUNDS;
  localparam int unsigned CNT_W       = $clog2(TotalCycles);

  bist_state_e state_q, state_d;
  logic        bist_end_q, bist_end_d;
  logic        cnt_clear, cnt_en, cnt_last;
  logic [CNT_W-1:0] cnt;

  bist_cycle_counter #(
    .Width (CNT_W),
    .Last  (TotalCycles - 1)
  ) u_cycle_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (cnt),
    .last   (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bist_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bist_end_q <= bist_end_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bist_end_d = bist_end_q;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StInit;
          bist_end_d = 1'b0;
          cnt_clear  = 1'b1;
        end
      end
      StInit: state_d = StRun;
      StRun: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d    = StIdle;
        bist_end_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pure Moore decode; the final round ends in finish rather than toggle.
  always_comb begin
    init     = (state_q == StInit);
    running  = (state_q == StRun);
    finish   = (state_q == StDone);
    toggle   = running && ((32'(cnt) % ROUND_LEN) == ROUND_LEN - 1) && !cnt_last;
    bist_end = bist_end_q;
  end

endmodule

// File: tb/tb_bist_controller.sv
// Directed self-checking bench for bist_controller at 4/2 and 3/1 sizing.
module tb_bist_controller;

  logic clk = 1'b0;
  logic reset_a, start_a, reset_b, start_b;
  logic init_a, running_a, toggle_a, finish_a, bist_end_a;
  logic init_b, running_b, toggle_b, finish_b, bist_end_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bist_controller u_dut_a (
    .clk      (clk),
    .reset    (reset_a),
    .start    (start_a),
    .init     (init_a),
    .running  (running_a),
    .toggle   (toggle_a),
    .finish   (finish_a),
    .bist_end (bist_end_a)
  );

  bist_controller #(
    .ROUND_LEN (3),
    .N_ROUNDS  (1)
  ) u_dut_b (
    .clk      (clk),
    .reset    (reset_b),
    .start    (start_b),
    .init     (init_b),
    .running  (running_b),
    .toggle   (toggle_b),
    .finish   (finish_b),
    .bist_end (bist_end_b)
  );

  // Output vector order: {init, running, toggle, finish, bist_end}
  task automatic chk(input string tag, input bit sel, input logic [4:0] exp);
    logic [4:0] obs;
    obs = sel ? {init_b, running_b, toggle_b, finish_b, bist_end_b}
              : {init_a, running_a, toggle_a, finish_a, bist_end_a};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  // Caller raises start just before; mid >= 0 pulses start after that running cycle.
  task automatic check_run(input string tag, input bit sel, input int rl, input int nr,
                           input int mid);
    bit tog;
    tick();
    chk({tag, ".init"}, sel, 5'b10000);
    set_start(sel, 1'b0);
    for (int i = 0; i < rl * nr; i++) begin
      tick();
      tog = ((i % rl) == rl - 1) && (i != rl * nr - 1);
      chk($sformatf("%s.run%0d", tag, i), sel, {1'b0, 1'b1, tog, 1'b0, 1'b0});
      set_start(sel, (i == mid) ? 1'b1 : 1'b0);
    end
    tick();
    chk({tag, ".finish"}, sel, 5'b00010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("%s.end%0d", tag, i), sel, 5'b00001);
    end
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    #13;
    reset_a = 1'b0;
    reset_b = 1'b0;
    chk("reset_a", 1'b0, 5'b00000);
    chk("reset_b", 1'b1, 5'b00000);

    // Basic run
    start_a = 1'b1;
    check_run("run1", 1'b0, 4, 2, -1);

    // Consecutive run after ~100 ns idle
    repeat (10) tick();
    chk("idle_hold", 1'b0, 5'b00001);
    start_a = 1'b1;
    check_run("run2", 1'b0, 4, 2, -1);

    // Start pulsed during running cycle 3 is ignored
    start_a = 1'b1;
    check_run("midstart", 1'b0, 4, 2, 2);

    // Reset during running cycle 2 aborts and clears bist_end
    start_a = 1'b1;
    tick();
    chk("abort.init", 1'b0, 5'b10000);
    start_a = 1'b0;
    tick();
    tick();
    chk("abort.run1", 1'b0, 5'b01000);
    reset_a = 1'b1;
    tick();
    chk("abort.reset", 1'b0, 5'b00000);
    reset_a = 1'b0;
    repeat (3) begin
      tick();
      chk("abort.idle", 1'b0, 5'b00000);
    end
    start_a = 1'b1;
    check_run("after_abort", 1'b0, 4, 2, -1);

    // Reset wins over start on the same edge
    reset_a = 1'b1;
    start_a = 1'b1;
    tick();
    chk("rst_start0", 1'b0, 5'b00000);
    tick();
    chk("rst_start1", 1'b0, 5'b00000);
    reset_a = 1'b0;
    check_run("post_rst", 1'b0, 4, 2, -1);

    // Short configuration: 3 cycles, single round, no toggle
    chk("b_idle", 1'b1, 5'b00000);
    start_b = 1'b1;
    check_run("sweep", 1'b1, 3, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
